// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared widths, quarter-phase codes and FSM encoding for the I2C master
// Rev    : 1.0
// ============================================================================
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [1:0] Q_LOW    = 2'd0;
  localparam logic [1:0] Q_RISE   = 2'd1;
  localparam logic [1:0] Q_SAMPLE = 2'd2;
  localparam logic [1:0] Q_FALL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_AACK  = 3'd3,
    S_WDATA = 3'd4,
    S_RDATA = 3'd5,
    S_DACK  = 3'd6,
    S_STOP  = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_clk_gen.sv
`default_nettype none
// ============================================================================
// Module : i2c_clk_gen
// Brief  : Quarter-phase tick divider and 2-bit phase counter, held clear in IDLE
// Rev    : 1.0
// ============================================================================
module i2c_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       i_clr,
  output logic       o_tick,
  output logic [1:0] o_phase
);

  logic [1:0] r_phase;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int CW = $clog2(CLK_DIV);
      localparam logic [CW-1:0] c_last = CW'(CLK_DIV - 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
          r_cnt <= '0;
        end else if (i_clr || o_tick) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign o_tick = !i_clr && (r_cnt == c_last);
    end else begin : g_nodiv
      assign o_tick = !i_clr;
    end
  endgenerate

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_phase <= 2'd0;
    end else if (i_clr) begin
      r_phase <= 2'd0;
    end else if (o_tick) begin
      r_phase <= r_phase + 2'd1;
    end
  end

  assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module : i2c_master_ctrl
// Brief  : Single-byte I2C master (START, addr+R/W, ACK, one data byte, STOP)
// Rev    : 1.0
// ============================================================================
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [DATA_W-1:0] rdata,
  output logic              scl_o,
  output logic              sda_o,
  output logic              sda_oe,
  input  logic              sda_i
);

  state_t            r_state;
  logic              r_rw;
  logic              r_ack;
  logic              r_fin;
  logic [2:0]        r_bit;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_sh;

  logic              w_clr;
  logic              w_tick;
  logic [1:0]        w_phase;
  logic              w_txbit;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_shin;

  assign w_clr   = (r_state == S_IDLE);
  assign w_txbit = LSB_FIRST ? r_sh[0] : r_sh[DATA_W-1];
  assign w_shift = LSB_FIRST ? {1'b0, r_sh[DATA_W-1:1]} : {r_sh[DATA_W-2:0], 1'b0};
  assign w_shin  = LSB_FIRST ? {sda_i, r_sh[DATA_W-1:1]} : {r_sh[DATA_W-2:0], sda_i};
  assign sda_o   = 1'b0;

  i2c_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .RESET   (RESET),
    .i_clr   (w_clr),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_rw    <= 1'b0;
      r_ack   <= 1'b0;
      r_fin   <= 1'b0;
      r_bit   <= 3'd0;
      r_wdata <= '0;
      r_sh    <= '0;
      scl_o   <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          scl_o  <= 1'b1;
          sda_oe <= 1'b0;
          if (start && !busy) begin
            r_rw    <= rw;
            r_wdata <= wdata;
            r_sh    <= {addr, rw};
            r_bit   <= 3'd0;
            busy    <= 1'b1;
            ack_err <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_phase == Q_SAMPLE) begin
              sda_oe <= 1'b1;
            end else if (w_phase == Q_FALL) begin
              scl_o   <= 1'b0;
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR, S_WDATA, S_RDATA: begin
          if (w_tick) begin
            case (w_phase)
              Q_LOW:    sda_oe <= (r_state == S_RDATA) ? 1'b0 : ~w_txbit;
              Q_RISE:   scl_o  <= 1'b1;
              Q_SAMPLE: if (r_state == S_RDATA) r_sh <= w_shin;
              default: begin
                scl_o <= 1'b0;
                r_bit <= r_bit + 3'd1;
                if (r_state != S_RDATA) r_sh <= w_shift;
                if (r_bit == 3'd7) begin
                  r_state <= (r_state == S_ADDR) ? S_AACK : S_DACK;
                end
              end
            endcase
          end
        end
        S_AACK, S_DACK: begin
          if (w_tick) begin
            case (w_phase)
              Q_LOW:    sda_oe <= 1'b0;
              Q_RISE:   scl_o  <= 1'b1;
              Q_SAMPLE: r_ack  <= sda_i;
              default: begin
                scl_o <= 1'b0;
                if (r_state == S_AACK) begin
                  if (r_ack) begin
                    ack_err <= 1'b1;
                    r_state <= S_STOP;
                  end else if (r_rw) begin
                    r_state <= S_RDATA;
                  end else begin
                    r_sh    <= r_wdata;
                    r_state <= S_WDATA;
                  end
                end else begin
                  // On a read the master's own NACK sits in this slot, so r_ack is ignored
                  if (r_rw) begin
                    rdata <= r_sh;
                  end else if (r_ack) begin
                    ack_err <= 1'b1;
                  end
                  r_state <= S_STOP;
                end
              end
            endcase
          end
        end
        S_STOP: begin
          if (r_fin) begin
            r_fin   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            case (w_phase)
              Q_LOW:    sda_oe <= 1'b1;
              Q_RISE:   scl_o  <= 1'b1;
              Q_SAMPLE: sda_oe <= 1'b0;
              default:  r_fin  <= 1'b1;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_master_ctrl
// Brief  : Directed bench with open-drain bus and simple slave models
// Rev    : 1.0
// ============================================================================
module tb_i2c_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // Instance A: CLK_DIV=4, LSB-first
  logic       start_a, rw_a, busy_a, done_a, ack_err_a, scl_a, sda_o_a, sda_oe_a;
  logic [6:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       sda_a;
  logic       a_pull = 1'b0;
  assign sda_a = (sda_oe_a || a_pull) ? 1'b0 : 1'b1;

  i2c_master_ctrl #(.CLK_DIV(4), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .RESET(rst_n), .start(start_a), .rw(rw_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a), .ack_err(ack_err_a), .rdata(rdata_a),
    .scl_o(scl_a), .sda_o(sda_o_a), .sda_oe(sda_oe_a), .sda_i(sda_a)
  );

  // Instance B: CLK_DIV=1, MSB-first
  logic       start_b, rw_b, busy_b, done_b, ack_err_b, scl_b, sda_o_b, sda_oe_b;
  logic [6:0] addr_b;
  logic [7:0] wdata_b, rdata_b;
  logic       sda_b;
  logic       b_pull = 1'b0;
  assign sda_b = (sda_oe_b || b_pull) ? 1'b0 : 1'b1;

  i2c_master_ctrl #(.CLK_DIV(1), .LSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .RESET(rst_n), .start(start_b), .rw(rw_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .ack_err(ack_err_b), .rdata(rdata_b),
    .scl_o(scl_b), .sda_o(sda_o_b), .sda_oe(sda_oe_b), .sda_i(sda_b)
  );

  // Slave A: LSB-first, watches the master's drive so its own pull never re-triggers it
  logic       s_ack  = 1'b1;
  logic [7:0] s_byte = 8'h00;
  int   a_cnt = 0, a_stops = 0, a_hi_chg = 0;
  logic a_bits [0:31];
  logic a_scl_d = 1'b1, a_sda_d = 1'b1;
  always @(scl_a or sda_oe_a) begin
    if (scl_a === 1'b1 && a_scl_d === 1'b1 && a_sda_d !== ~sda_oe_a) begin
      a_hi_chg++;
      if (sda_oe_a === 1'b1) a_cnt = 0;
      else a_stops++;
    end else if (scl_a === 1'b1 && a_scl_d === 1'b0) begin
      if (a_cnt < 32) a_bits[a_cnt] = ~sda_oe_a;
      a_cnt++;
    end else if (scl_a === 1'b0 && a_scl_d === 1'b1) begin
      a_pull = 1'b0;
      if (s_ack) begin
        if (a_cnt == 8) a_pull = 1'b1;
        else if (a_bits[0] === 1'b1 && a_cnt >= 9 && a_cnt <= 16) a_pull = ~s_byte[a_cnt-9];
        else if (a_bits[0] === 1'b0 && a_cnt == 17) a_pull = 1'b1;
      end
    end
    a_scl_d = scl_a;
    a_sda_d = ~sda_oe_a;
  end

  // Slave B: write-only ACKer, MSB-first capture, counts SDA edges while SCL high
  int   b_cnt = 0, b_hi_chg = 0;
  logic b_bits [0:31];
  logic b_scl_d = 1'b1, b_sda_d = 1'b1;
  always @(scl_b or sda_oe_b) begin
    if (scl_b === 1'b1 && b_scl_d === 1'b1 && b_sda_d !== ~sda_oe_b) begin
      b_hi_chg++;
      if (sda_oe_b === 1'b1) b_cnt = 0;
    end else if (scl_b === 1'b1 && b_scl_d === 1'b0) begin
      if (b_cnt < 32) b_bits[b_cnt] = ~sda_oe_b;
      b_cnt++;
    end else if (scl_b === 1'b0 && b_scl_d === 1'b1) begin
      b_pull = (b_cnt == 8 || b_cnt == 17);
    end
    b_scl_d = scl_b;
    b_sda_d = ~sda_oe_b;
  end

  function automatic logic [7:0] a_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a_bits[base+i];
    return r;
  endfunction

  function automatic logic [7:0] b_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b_bits[base+i];
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_a(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_wd);
    @(negedge clk);
    start_a = 1'b1; rw_a = i_rw; addr_a = i_addr; wdata_a = i_wd;
    @(posedge clk); #1;
    start_a = 1'b0;
    check_val("busy_after_accept", 32'(busy_a), 32'd1);
  endtask

  // Counts edges after the accept edge until done; optionally fires a stray start pulse
  task automatic wait_done_a(input int pulse_at, output int lat);
    lat = 0;
    for (int n = 1; n <= 3000 && lat == 0; n++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done_a) lat = n;
      else if (n == pulse_at) begin
        start_a = 1'b1; rw_a = 1'b1; addr_a = 7'h7F; wdata_a = 8'h00;
      end
    end
    if (lat == 0) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  int lat, s0;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; rw_a = 1'b0; addr_a = 7'h00; wdata_a = 8'h00;
    start_b = 1'b0; rw_b = 1'b0; addr_b = 7'h00; wdata_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_scl",     32'(scl_a),     32'd1);
    check_val("rst_sda_oe",  32'(sda_oe_a),  32'd0);
    check_val("rst_busy",    32'(busy_a),    32'd0);
    check_val("rst_done",    32'(done_a),    32'd0);
    check_val("rst_ack_err", 32'(ack_err_a), 32'd0);
    check_val("rst_rdata",   32'(rdata_a),   32'h00);
    @(negedge clk) rst_n = 1'b1;

    // 1: write 0x05 / 0xCC with ACKs
    s_ack = 1'b1;
    s0 = a_stops;
    begin_a(1'b0, 7'h05, 8'hCC);
    wait_done_a(0, lat);
    check_val("t1_latency",   32'(lat),        32'd321);
    check_val("t1_ack_err",   32'(ack_err_a),  32'd0);
    check_val("t1_busy_done", 32'(busy_a),     32'd0);
    check_val("t1_addr_wire", 32'(a_byte(0)),  32'h0A);
    check_val("t1_data_wire", 32'(a_byte(9)),  32'hCC);
    check_val("t1_stop",      32'(a_stops-s0), 32'd1);
    @(posedge clk); #1;
    check_val("t1_done_pulse", 32'(done_a), 32'd0);

    // 2: read 0x05, slave returns 0xA5, master NACKs
    s_byte = 8'hA5;
    s0 = a_stops;
    begin_a(1'b1, 7'h05, 8'h00);
    wait_done_a(0, lat);
    check_val("t2_latency",  32'(lat),        32'd321);
    check_val("t2_rdata",    32'(rdata_a),    32'hA5);
    check_val("t2_ack_err",  32'(ack_err_a),  32'd0);
    check_val("t2_addr_wire",32'(a_byte(0)),  32'h0B);
    check_val("t2_nack",     32'(a_bits[17]), 32'd1);
    check_val("t2_stop",     32'(a_stops-s0), 32'd1);

    // 3: address NACK
    s_ack = 1'b0;
    s0 = a_stops;
    begin_a(1'b0, 7'h05, 8'h11);
    wait_done_a(0, lat);
    check_val("t3_latency", 32'(lat),        32'd177);
    check_val("t3_ack_err", 32'(ack_err_a),  32'd1);
    check_val("t3_rdata",   32'(rdata_a),    32'hA5);
    check_val("t3_sclrise", 32'(a_cnt),      32'd10);
    check_val("t3_stop",    32'(a_stops-s0), 32'd1);
    s_ack = 1'b1;

    // 4: reset asserted while SCL low in WDATA bit 3 (wdata 0x00 -> SDA pulled)
    begin_a(1'b0, 7'h05, 8'h00);
    repeat (214) @(posedge clk);
    #1;
    check_val("t4_pre_scl",    32'(scl_a),    32'd0);
    check_val("t4_pre_sda_oe", 32'(sda_oe_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t4_rst_scl",    32'(scl_a),    32'd1);
    check_val("t4_rst_sda_oe", 32'(sda_oe_a), 32'd0);
    check_val("t4_rst_busy",   32'(busy_a),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    begin_a(1'b0, 7'h05, 8'hCC);
    wait_done_a(0, lat);
    check_val("t4_latency",   32'(lat),       32'd321);
    check_val("t4_data_wire", 32'(a_byte(9)), 32'hCC);
    check_val("t4_ack_err",   32'(ack_err_a), 32'd0);

    // 5: stray start mid-transfer, then start raised in the done cycle
    begin_a(1'b0, 7'h05, 8'h3C);
    wait_done_a(100, lat);
    check_val("t5_latency",   32'(lat),        32'd321);
    check_val("t5_addr_wire", 32'(a_byte(0)),  32'h0A);
    check_val("t5_data_wire", 32'(a_byte(9)),  32'h3C);
    check_val("t5_busy_done", 32'(busy_a),     32'd0);
    s_byte = 8'h5A;
    start_a = 1'b1; rw_a = 1'b1; addr_a = 7'h05; wdata_a = 8'h00;
    @(posedge clk); #1;
    start_a = 1'b0;
    check_val("t5_chain_busy", 32'(busy_a), 32'd1);
    wait_done_a(0, lat);
    check_val("t5_chain_latency", 32'(lat),     32'd321);
    check_val("t5_chain_rdata",   32'(rdata_a), 32'h5A);

    // 6: CLK_DIV=1 MSB-first write 0x50 / 0x3C
    b_hi_chg = 0;
    @(negedge clk);
    start_b = 1'b1; rw_b = 1'b0; addr_b = 7'h50; wdata_b = 8'h3C;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 0;
    for (int n = 1; n <= 500 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (done_b) lat = n;
    end
    check_val("t6_latency",   32'(lat),       32'd81);
    check_val("t6_addr_wire", 32'(b_byte(0)), 32'hA0);
    check_val("t6_data_wire", 32'(b_byte(9)), 32'h3C);
    check_val("t6_ack_err",   32'(ack_err_b), 32'd0);
    check_val("t6_sda_hi_chg",32'(b_hi_chg),  32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
